// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared opcode, funct, ALU and state encodings
//
// Purpose: constants and the FSM state type used by the multicycle MIPS
// control unit and its ALU decoder.
// Ports: none (package).
package multicycle_controller_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Main-decoder to ALU-decoder operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_e;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - aluop/funct to ALU control decoder
//
// Purpose: purely combinational ALU decoder.
// Ports:
//   aluop      in  2  operation class from the main FSM
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation select
//   bad_funct  out 1  funct not supported (only meaningful when aluop selects funct)
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  always_comb begin
    alucontrol = ALU_ADD;
    bad_funct  = 1'b0;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          // Unsupported funct still performs an add so the datapath stays defined.
          default: bad_funct  = 1'b1;
        endcase
      end
      // aluop 00 and the unused 11 both decode as add
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS sequencing control unit (Moore FSM)
//
// Purpose: walks each instruction through fetch/decode/execute/writeback and
// drives the datapath control inputs.
// Ports:
//   clk, reset (sync, active-low)
//   op[5:0], funct[5:0], zero          from datapath
//   pcen, pcsrc[1:0], irwrite, lord, memwrite, alusrca, alusrcb[1:0],
//   regdst, memtoreg, regwrite, alucontrol[2:0], illegal_op   to datapath
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       irwrite,
  output logic       lord,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch, bne;
  logic       irwrite_s, memwrite_s, regwrite_s;
  logic       bad_op, bad_funct;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    lord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    aluop      = ALUOP_ADD;
    pcsrc      = 2'b00;
    bad_op     = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b01;
        pcwrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE: begin
            if (ENABLE_BNE) state_d = S_BNEEX;
            else            bad_op  = 1'b1;
          end
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      bad_op  = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        lord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        lord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        bne     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .bad_funct  (bad_funct)
  );

  // Every write-type enable is masked while reset is low so an abandoned
  // instruction cannot commit anything in the reset cycle.
  assign pcen       = reset & (pcwrite | (branch & zero) | (bne & ~zero));
  assign irwrite    = reset & irwrite_s;
  assign memwrite   = reset & memwrite_s;
  assign regwrite   = reset & regwrite_s;
  assign illegal_op = reset & (bad_op | (bad_funct & (state_q == S_RTYPEEX)));

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;

  logic       pcen0, irwrite0, lord0, memwrite0, alusrca0, regdst0, memtoreg0, regwrite0, ill0;
  logic [1:0] pcsrc0, alusrcb0;
  logic [2:0] aluc0;
  logic       pcen1, irwrite1, lord1, memwrite1, alusrca1, regdst1, memtoreg1, regwrite1, ill1;
  logic [1:0] pcsrc1, alusrcb1;
  logic [2:0] aluc1;

  always #5 clk = ~clk;

  multicycle_controller #(.ENABLE_BNE(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen0), .pcsrc(pcsrc0), .irwrite(irwrite0), .lord(lord0), .memwrite(memwrite0),
    .alusrca(alusrca0), .alusrcb(alusrcb0), .regdst(regdst0), .memtoreg(memtoreg0),
    .regwrite(regwrite0), .alucontrol(aluc0), .illegal_op(ill0)
  );

  multicycle_controller #(.ENABLE_BNE(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen1), .pcsrc(pcsrc1), .irwrite(irwrite1), .lord(lord1), .memwrite(memwrite1),
    .alusrca(alusrca1), .alusrcb(alusrcb1), .regdst(regdst1), .memtoreg(memtoreg1),
    .regwrite(regwrite1), .alucontrol(aluc1), .illegal_op(ill1)
  );

  // Packed view: {pcen, pcsrc, irwrite, lord, memwrite, alusrca, alusrcb,
  //               regdst, memtoreg, regwrite, alucontrol, illegal_op}
  logic [15:0] o0, o1;
  assign o0 = {pcen0, pcsrc0, irwrite0, lord0, memwrite0, alusrca0, alusrcb0,
               regdst0, memtoreg0, regwrite0, aluc0, ill0};
  assign o1 = {pcen1, pcsrc1, irwrite1, lord1, memwrite1, alusrca1, alusrcb1,
               regdst1, memtoreg1, regwrite1, aluc1, ill1};

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  // Instruction classes: 0 lw, 1 sw, 2 R, 3 beq, 4 bne, 5 addi, 6 j; -1 illegal.
  function automatic int classify(input logic [5:0] o, input bit en_bne);
    case (o)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return 2;
      6'b000100: return 3;
      6'b000101: return en_bne ? 4 : -1;
      6'b001000: return 5;
      6'b000010: return 6;
      default:   return -1;
    endcase
  endfunction

  function automatic int cycles_of(input int cls);
    case (cls)
      0:       return 5;
      1, 2, 5: return 4;
      default: return 3;
    endcase
  endfunction

  // {bad, alucontrol} for an R-type funct
  function automatic logic [3:0] rfunc(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b1010;
    endcase
  endfunction

  function automatic logic [15:0] expect_out(input int step, input int cls, input logic [5:0] o,
                                             input logic [5:0] f, input logic z, input logic rst,
                                             input bit en_bne);
    logic e_pcen, e_ir, e_lord, e_mw, e_asa, e_rd, e_m2r, e_rw, e_ill;
    logic [1:0] e_pcsrc, e_asb;
    logic [2:0] e_aluc;
    logic [3:0] rf;
    {e_pcen, e_ir, e_lord, e_mw, e_asa, e_rd, e_m2r, e_rw, e_ill} = '0;
    e_pcsrc = 2'b00;
    e_asb   = 2'b00;
    e_aluc  = 3'b010;
    rf      = rfunc(f);
    if (step == 0) begin
      e_ir = 1'b1; e_asb = 2'b01; e_pcen = 1'b1;
    end else if (step == 1) begin
      e_asb = 2'b11;
      e_ill = (classify(o, en_bne) < 0);
    end else begin
      case (cls)
        0, 1: begin
          if (step == 2) begin e_asa = 1'b1; e_asb = 2'b10; end
          else if (step == 3) begin e_lord = 1'b1; e_mw = (cls == 1); end
          else begin e_m2r = 1'b1; e_rw = 1'b1; end
        end
        2: begin
          if (step == 2) begin e_asa = 1'b1; e_aluc = rf[2:0]; e_ill = rf[3]; end
          else begin e_rd = 1'b1; e_rw = 1'b1; end
        end
        3, 4: begin
          e_asa = 1'b1; e_aluc = 3'b110; e_pcsrc = 2'b01;
          e_pcen = (cls == 3) ? z : ~z;
        end
        5: begin
          if (step == 2) begin e_asa = 1'b1; e_asb = 2'b10; end
          else e_rw = 1'b1;
        end
        default: begin e_pcsrc = 2'b10; e_pcen = 1'b1; end
      endcase
    end
    if (!rst) {e_pcen, e_ir, e_mw, e_rw, e_ill} = '0;
    return {e_pcen, e_pcsrc, e_ir, e_lord, e_mw, e_asa, e_asb, e_rd, e_m2r, e_rw, e_aluc, e_ill};
  endfunction

  int m_step[2];
  int m_cls[2];
  bit armed = 1'b0;

  initial begin
    m_step[0] = 0; m_step[1] = 0; m_cls[0] = 0; m_cls[1] = 0;
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) m_step[d] <= 0;
      else if (m_step[d] == 0) m_step[d] <= 1;
      else if (m_step[d] == 1) begin
        if (classify(op, d == 0) >= 0) begin
          m_cls[d]  <= classify(op, d == 0);
          m_step[d] <= 2;
        end else m_step[d] <= 0;
      end else if (m_step[d] + 1 >= cycles_of(m_cls[d])) m_step[d] <= 0;
      else m_step[d] <= m_step[d] + 1;
    end
    armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        logic [15:0] e, a;
        e = expect_out(m_step[d], m_cls[d], op, funct, zero, reset, d == 0);
        a = (d == 0) ? o0 : o1;
        n_assert++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL model dut%0d step%0d t=%0t: got %h expected %h", d, m_step[d], $time, a, e);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] obs0[8];
  logic [15:0] obs1[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) next_cycle();
    reset = 1'b1;
  endtask

  // Called during a FETCH cycle; records both DUTs' outputs for n cycles.
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
    op = o; funct = f; zero = z;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      obs0[s] = o0;
      obs1[s] = o1;
      next_cycle();
    end
  endtask

  logic [5:0] r_fn[6]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
  logic [2:0] r_aluc[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
  logic       r_ill[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("reset_irwrite", 32'(irwrite0), 32'd0);
    chk("reset_pcen", 32'(pcen0), 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("release_irwrite", 32'(irwrite0), 32'd1);
    chk("release_pcen", 32'(pcen0), 32'd1);

    // lw: 5 cycles then back to FETCH
    do_reset(1);
    run(6'b100011, 6'd0, 1'b0, 6);
    chk("lw_fetch_ir", 32'(obs0[0][12]), 32'd1);
    chk("lw_memrd_lord", 32'(obs0[3][11]), 32'd1);
    chk("lw_memwb_rw_m2r_rd", 32'({obs0[4][4], obs0[4][5], obs0[4][6]}), 32'b110);
    chk("lw_back_fetch", 32'(obs0[5][12]), 32'd1);

    // sw without reset: write strobe in 4th cycle
    do_reset(1);
    run(6'b101011, 6'd0, 1'b0, 4);
    chk("sw_memwrite", 32'(obs0[3][10]), 32'd1);

    // sw with reset held low 3 cycles while in MEMWR
    do_reset(1);
    run(6'b101011, 6'd0, 1'b0, 3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_memwr_memwrite0", 32'(memwrite0), 32'd0);
      chk("rst_memwr_memwrite1", 32'(memwrite1), 32'd0);
      if (i == 0) chk("rst_memwr_lord", 32'(lord0), 32'd1);
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_release_irwrite", 32'(irwrite0), 32'd1);
    chk("rst_release_pcen", 32'(pcen0), 32'd1);
    next_cycle();

    // beq taken / not taken
    do_reset(1);
    run(6'b000100, 6'd0, 1'b1, 4);
    chk("beq_taken_pcen_pcsrc", 32'({obs0[2][15], obs0[2][14:13]}), 32'b101);
    chk("beq_back_fetch", 32'(obs0[3][12]), 32'd1);
    do_reset(1);
    run(6'b000100, 6'd0, 1'b0, 3);
    chk("beq_nottaken_pcen", 32'(obs0[2][15]), 32'd0);

    // bne: taken on dut0, illegal on dut1
    do_reset(1);
    run(6'b000101, 6'd0, 1'b0, 3);
    chk("bne_taken_pcen", 32'(obs0[2][15]), 32'd1);
    chk("bne_dis_illegal", 32'(obs1[1][0]), 32'd1);
    chk("bne_dis_fetch", 32'(obs1[2][12]), 32'd1);

    // R-type funct table
    for (int k = 0; k < 6; k++) begin
      do_reset(1);
      run(6'b000000, r_fn[k], 1'b0, 4);
      chk($sformatf("rtype_aluc_%b", r_fn[k]), 32'(obs0[2][3:1]), 32'(r_aluc[k]));
      chk($sformatf("rtype_ill_%b", r_fn[k]), 32'(obs0[2][0]), 32'(r_ill[k]));
      chk($sformatf("rtype_wb_%b", r_fn[k]), 32'({obs0[3][4], obs0[3][6]}), 32'b11);
    end

    // addi writeback to rt
    do_reset(1);
    run(6'b001000, 6'd0, 1'b0, 4);
    chk("addi_wb_rw_rd", 32'({obs0[3][4], obs0[3][6]}), 32'b10);

    // j
    do_reset(1);
    run(6'b000010, 6'd0, 1'b0, 3);
    chk("j_pcsrc_pcen", 32'({obs0[2][14:13], obs0[2][15]}), 32'b101);

    // illegal opcode
    do_reset(1);
    run(6'b111111, 6'd0, 1'b0, 3);
    chk("illop_pulse", 32'(obs0[1][0]), 32'd1);
    chk("illop_no_writes", 32'({obs0[1][4], obs0[1][10], obs0[2][4], obs0[2][10]}), 32'd0);
    chk("illop_fetch_next", 32'(obs0[2][12]), 32'd1);

    do_reset(1);
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
